// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package mips_fetch_pkg;

   typedef enum logic [1:0] {
      S_BOOT,
      S_RUN,
      S_SQUASH
   } fetch_state_t;

   localparam logic [31:0] PC_STEP   = 32'd4;
   localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux: jump > branch > stall (hold) > sequential, with word alignment.
module pc_next_sel
   import mips_fetch_pkg::*;
(
   input  logic [31:0] pc_i,
   input  logic        stall_i,
   input  logic        branch_taken_i,
   input  logic [31:0] branch_target_i,
   input  logic        jump_i,
   input  logic [31:0] jump_target_i,
   output logic [31:0] pc_next_o,
   output logic        redirect_o
);

   always_comb begin
      redirect_o = jump_i | branch_taken_i;
      pc_next_o  = pc_i + PC_STEP;
      if (jump_i) begin
         pc_next_o = jump_target_i & ~32'd3;
      end else if (branch_taken_i) begin
         pc_next_o = branch_target_i & ~32'd3;
      end else if (stall_i) begin
         pc_next_o = pc_i;
      end
   end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage: PC, 1-cycle memory tracking and IF/ID register.
// Define FETCH_PERF_CNT_EN to add the fetch_cnt / bubble_cnt performance counters.
module pc_fetch_unit
   import mips_fetch_pkg::*;
#(
   parameter int unsigned ADDR_W   = 10,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              flush,
   input  logic              branch_taken,
   input  logic [31:0]       branch_target,
   input  logic              jump,
   input  logic [31:0]       jump_target,
   input  logic [31:0]       instr_in,
   output logic [ADDR_W-1:0] addr_prog,
   output logic [31:0]       if_id_instr,
   output logic [31:0]       if_id_pc4,
`ifdef FETCH_PERF_CNT_EN
   output logic [31:0]       fetch_cnt,
   output logic [31:0]       bubble_cnt,
`endif
   output logic              if_id_valid
);

   logic [31:0]  pc_q, pc_d;
   logic [31:0]  fpc_q, fpc_d;
   fetch_state_t state_q, state_d;
   logic         held_q, held_d;
   logic [31:0]  held_instr_q, held_instr_d;
   logic [31:0]  instr_d, pc4_d;
   logic         valid_d;
   logic         redirect;
   logic         update;
   logic [31:0]  fetch_word;

   pc_next_sel u_pc_next_sel (
      .pc_i            (pc_q),
      .stall_i         (stall),
      .branch_taken_i  (branch_taken),
      .branch_target_i (branch_target),
      .jump_i          (jump),
      .jump_target_i   (jump_target),
      .pc_next_o       (pc_d),
      .redirect_o      (redirect)
   );

   assign addr_prog = pc_q[ADDR_W+1:2];
   assign update    = redirect | ~stall;

   // The memory keeps returning the word for the frozen pc during a stall, which overwrites
   // the word for fpc; the first stalled edge parks that word so it is not lost on release.
   assign fetch_word = held_q ? held_instr_q : instr_in;

   always_comb begin
      fpc_d        = fpc_q;
      state_d      = state_q;
      held_d       = held_q;
      held_instr_d = held_instr_q;
      instr_d      = if_id_instr;
      pc4_d        = if_id_pc4;
      valid_d      = if_id_valid;
      if (redirect) begin
         fpc_d   = pc_q;
         state_d = S_SQUASH;
         held_d  = 1'b0;
         instr_d = fetch_word;
         pc4_d   = fpc_q + PC_STEP;
         valid_d = 1'b0;
      end else if (stall) begin
         if (!held_q) begin
            held_d       = 1'b1;
            held_instr_d = instr_in;
         end
      end else begin
         fpc_d   = pc_q;
         state_d = S_RUN;
         held_d  = 1'b0;
         instr_d = fetch_word;
         pc4_d   = fpc_q + PC_STEP;
         valid_d = (state_q == S_RUN) & ~flush;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q         <= RESET_PC;
         fpc_q        <= 32'd0;
         state_q      <= S_BOOT;
         held_q       <= 1'b0;
         held_instr_q <= INSTR_NOP;
         if_id_instr  <= INSTR_NOP;
         if_id_pc4    <= 32'd0;
         if_id_valid  <= 1'b0;
      end else begin
         pc_q         <= pc_d;
         fpc_q        <= fpc_d;
         state_q      <= state_d;
         held_q       <= held_d;
         held_instr_q <= held_instr_d;
         if_id_instr  <= instr_d;
         if_id_pc4    <= pc4_d;
         if_id_valid  <= valid_d;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_cnt  <= 32'd0;
         bubble_cnt <= 32'd0;
      end else begin
         fetch_cnt  <= fetch_cnt + {31'd0, update & valid_d};
         bubble_cnt <= bubble_cnt + {31'd0, update & ~valid_d};
      end
   end
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit with a 1-cycle-latency instruction memory model.
module tb_pc_fetch_unit;

   localparam int unsigned ADDR_W   = 10;
   localparam logic [31:0] RESET_PC = 32'h0000_0BC0;

   logic              clk;
   logic              rst;
   logic              stall;
   logic              flush;
   logic              branch_taken;
   logic [31:0]       branch_target;
   logic              jump;
   logic [31:0]       jump_target;
   logic [31:0]       instr_in;
   logic [ADDR_W-1:0] addr_prog;
   logic [31:0]       if_id_instr;
   logic [31:0]       if_id_pc4;
   logic              if_id_valid;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0]       fetch_cnt;
   logic [31:0]       bubble_cnt;
`endif

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   logic [31:0] exp_instr_q[$];
   logic [31:0] exp_pc4_q[$];
   logic        hold_edge;
   logic        rst_edge;

   pc_fetch_unit #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .flush         (flush),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .jump          (jump),
      .jump_target   (jump_target),
      .instr_in      (instr_in),
      .addr_prog     (addr_prog),
      .if_id_instr   (if_id_instr),
      .if_id_pc4     (if_id_pc4),
`ifdef FETCH_PERF_CNT_EN
      .fetch_cnt     (fetch_cnt),
      .bubble_cnt    (bubble_cnt),
`endif
      .if_id_valid   (if_id_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Word 0x2F0+k holds 0xA000_0000+k.
   function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
      return 32'hA000_0000 + (32'(a) - 32'h0000_02F0);
   endfunction

   always @(posedge clk) instr_in <= mem_word(addr_prog);

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %08h, expected %08h (t=%0t)", tag, got, exp, $time);
   endtask

   task automatic push_word(input logic [31:0] bpc);
      exp_instr_q.push_back(mem_word(bpc[ADDR_W+1:2]));
      exp_pc4_q.push_back(bpc + 32'd4);
   endtask

   task automatic push_run(input logic [31:0] bpc, input int n);
      for (int i = 0; i < n; i++) push_word(bpc + 32'(4 * i));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Pure stall edges leave IF/ID untouched, so only other edges deliver a new word.
   always @(posedge clk) begin
      hold_edge <= stall & ~jump & ~branch_taken;
      rst_edge  <= rst;
   end

   always @(negedge clk) begin
      logic [31:0] e_i;
      logic [31:0] e_p;
      if (if_id_valid === 1'b1 && hold_edge === 1'b0 && rst_edge === 1'b0) begin
         if (exp_instr_q.size() == 0) begin
            check_eq("sb_unexpected", {31'd0, if_id_valid}, 32'd0);
         end else begin
            e_i = exp_instr_q.pop_front();
            e_p = exp_pc4_q.pop_front();
            check_eq("sb_instr", if_id_instr, e_i);
            check_eq("sb_pc4", if_id_pc4, e_p);
         end
      end
   end

   initial begin
      rst           = 1'b1;
      stall         = 1'b0;
      flush         = 1'b0;
      branch_taken  = 1'b0;
      branch_target = 32'd0;
      jump          = 1'b0;
      jump_target   = 32'd0;

      repeat (2) step();
      check_eq("rst_valid", {31'd0, if_id_valid}, 32'd0);
      check_eq("rst_instr", if_id_instr, 32'd0);
      check_eq("rst_pc4", if_id_pc4, 32'd0);
      check_eq("rst_addr", 32'(addr_prog), 32'h2F0);

      // Sequential run from RESET_PC.
      push_run(32'h0BC0, 32);
      rst = 1'b0;
      step();
      check_eq("boot_bubble", {31'd0, if_id_valid}, 32'd0);
      check_eq("boot_addr", 32'(addr_prog), 32'h2F1);
      step();
      check_eq("first_valid", {31'd0, if_id_valid}, 32'd1);
      check_eq("seq_addr2", 32'(addr_prog), 32'h2F2);
      repeat (31) step();
      check_eq("seq_addr33", 32'(addr_prog), 32'h311);

      // Branch to an unaligned target.
      branch_taken  = 1'b1;
      branch_target = 32'h0000_0C03;
      step();
      branch_taken = 1'b0;
      check_eq("br_addr", 32'(addr_prog), 32'h300);
      check_eq("br_valid", {31'd0, if_id_valid}, 32'd0);
      push_run(32'h0C00, 7);
      step();
      check_eq("br_squash", {31'd0, if_id_valid}, 32'd0);
      step();
      check_eq("br_target_valid", {31'd0, if_id_valid}, 32'd1);
      repeat (4) step();

      // Three-cycle stall.
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check_eq("stall_addr", 32'(addr_prog), 32'h306);
         check_eq("stall_instr", if_id_instr, 32'hA000_0014);
         check_eq("stall_pc4", if_id_pc4, 32'h0000_0C14);
         check_eq("stall_valid", {31'd0, if_id_valid}, 32'd1);
      end
      stall = 1'b0;
      repeat (2) step();

      // Jump beats branch and stall in the same cycle.
      jump          = 1'b1;
      jump_target   = 32'h0000_0D00;
      branch_taken  = 1'b1;
      branch_target = 32'h0000_0E00;
      stall         = 1'b1;
      step();
      jump         = 1'b0;
      branch_taken = 1'b0;
      stall        = 1'b0;
      check_eq("jump_wins_addr", 32'(addr_prog), 32'h340);
      check_eq("jump_valid", {31'd0, if_id_valid}, 32'd0);
      push_run(32'h0D00, 2);
      push_word(32'h0D0C);
      push_word(32'h0D10);
      push_word(32'h0D14);
      repeat (3) step();

      // Flush kills one word, pc keeps stepping.
      flush = 1'b1;
      step();
      flush = 1'b0;
      check_eq("flush_valid", {31'd0, if_id_valid}, 32'd0);
      check_eq("flush_addr", 32'(addr_prog), 32'h344);
      step();
      check_eq("flush_next_valid", {31'd0, if_id_valid}, 32'd1);
      step();

      // Stall overrides flush.
      stall = 1'b1;
      flush = 1'b1;
      step();
      check_eq("fs_valid", {31'd0, if_id_valid}, 32'd1);
      check_eq("fs_pc4", if_id_pc4, 32'h0000_0D14);
      stall = 1'b0;
      flush = 1'b0;
      step();

      // Reset while squashing.
      branch_taken  = 1'b1;
      branch_target = 32'h0000_0E00;
      step();
      branch_taken = 1'b0;
      rst          = 1'b1;
      step();
      check_eq("rst_sq_addr", 32'(addr_prog), 32'h2F0);
      check_eq("rst_sq_valid", {31'd0, if_id_valid}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
      check_eq("rst_sq_fetch_cnt", fetch_cnt, 32'd0);
      check_eq("rst_sq_bubble_cnt", bubble_cnt, 32'd0);
`endif
      rst = 1'b0;
      push_word(32'h0BC0);
      repeat (2) step();

      // Reset while stalled.
      stall = 1'b1;
      rst   = 1'b1;
      step();
      check_eq("rst_st_addr", 32'(addr_prog), 32'h2F0);
      check_eq("rst_st_valid", {31'd0, if_id_valid}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
      check_eq("rst_st_fetch_cnt", fetch_cnt, 32'd0);
      check_eq("rst_st_bubble_cnt", bubble_cnt, 32'd0);
`endif
      stall = 1'b0;
      rst   = 1'b0;

      // Jump to the top of the address space; pc wraps to zero.
      jump        = 1'b1;
      jump_target = 32'hFFFF_FFFF;
      step();
      jump = 1'b0;
      check_eq("wrap_top_addr", 32'(addr_prog), 32'h3FF);
      push_word(32'hFFFF_FFFC);
      push_word(32'h0000_0000);
      step();
      check_eq("wrap_zero_addr", 32'(addr_prog), 32'h000);
      repeat (2) step();
      stall = 1'b1;
      repeat (3) step();
      check_eq("sb_drain", 32'(exp_instr_q.size()), 32'd0);
`ifdef FETCH_PERF_CNT_EN
      check_eq("end_fetch_cnt", fetch_cnt, 32'd2);
      check_eq("end_bubble_cnt", bubble_cnt, 32'd2);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
